// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: pin synchronisers, ps2c glitch filter, 11-bit frame FSM,
// E0/F0 prefix tracking and held state of five game keys. Optional macro: WASD_ALIAS_EN.
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [4:0] move_state,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t        state, state_next;
  logic [1:0]    c_sync, d_sync;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          flip, strobe;
  logic [10:0]   shreg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          frame_ok;
  logic [7:0]    rx_byte;
  logic          ext, brk;
  logic [3:0]    arrow;
  logic          space;

  // Synchronisers idle high, matching an undriven PS/2 bus.
  // NOTE: every clocked process uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
    end
  end

  // Filtered level flips on the FILTER_LEN-th consecutive differing sample.
  assign flip   = (c_sync[1] != filt) && (fcnt == FW'(FILTER_LEN - 1));
  assign strobe = flip && filt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (c_sync[1] == filt) begin
      fcnt <= '0;
    end else if (flip) begin
      filt <= c_sync[1];
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign rx_byte  = shreg[8:1];
  assign frame_ok = !shreg[0] && shreg[10] && (^shreg[9:1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: next state takes a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (strobe) state_next = RECV;
      RECV: begin
        if (strobe && bit_cnt == 4'd10) state_next = CHECK;
        else if (!strobe && tmo_hit)    state_next = IDLE;
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bits arrive LSB first, so they enter at the top and end with start bit in shreg[0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (strobe) begin
            shreg   <= {d_sync[1], shreg[10:1]};
            bit_cnt <= 4'd1;
          end
        end
        RECV: begin
          if (strobe) begin
            shreg   <= {d_sync[1], shreg[10:1]};
            bit_cnt <= bit_cnt + 1'b1;
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

`ifdef WASD_ALIAS_EN
  logic [3:0] wasd;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_code  <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      arrow      <= '0;
      space      <= 1'b0;
`ifdef WASD_ALIAS_EN
      wasd       <= '0;
`endif
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == CHECK) begin
        if (frame_ok) begin
          code_valid <= 1'b1;
          scan_code  <= rx_byte;
          if (rx_byte == 8'hE0) begin
            ext <= 1'b1;
          end else if (rx_byte == 8'hF0) begin
            brk <= 1'b1;
          end else begin
            ext <= 1'b0;
            brk <= 1'b0;
            if (ext) begin
              case (rx_byte)
                8'h75:   arrow[0] <= !brk;
                8'h6B:   arrow[1] <= !brk;
                8'h74:   arrow[2] <= !brk;
                8'h72:   arrow[3] <= !brk;
                default: ;
              endcase
            end else begin
              case (rx_byte)
                8'h29:   space   <= !brk;
`ifdef WASD_ALIAS_EN
                8'h1D:   wasd[0] <= !brk;
                8'h1C:   wasd[1] <= !brk;
                8'h23:   wasd[2] <= !brk;
                8'h1B:   wasd[3] <= !brk;
`endif
                default: ;
              endcase
            end
          end
        end else begin
          frame_err <= 1'b1;
          ext       <= 1'b0;
          brk       <= 1'b0;
        end
      end else if (state == RECV && !strobe && tmo_hit) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

`ifdef WASD_ALIAS_EN
  assign move_state = {space, arrow | wasd};
`else
  assign move_state = {space, arrow};
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of whole frames with expected key state,
// then hand sequences for timeout, ps2c glitches and reset mid-frame.
module tb_ps2_key_decoder;

  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [4:0] move_state;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d),
    .move_state(move_state), .scan_code(scan_code),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ecnt = 0;

  always @(negedge clk) begin
    if (code_valid) vcnt++;
    if (frame_err)  ecnt++;
  end

  typedef struct {
    logic [7:0] data;
    bit         bad;
    logic [4:0] exp_move;
    logic [7:0] exp_scan;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

`ifdef WASD_ALIAS_EN
  localparam logic [4:0] W = 5'b00001;
`else
  localparam logic [4:0] W = 5'b00000;
`endif

  task automatic add(input logic [7:0] d, input bit bad, input logic [4:0] m, input logic [7:0] s);
    vecs[nvec].data     = d;
    vecs[nvec].bad      = bad;
    vecs[nvec].exp_move = m;
    vecs[nvec].exp_scan = s;
    nvec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad);
    logic par;
    par = (~^d) ^ bad;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      wait_cyc(HALF);
      ps2c = 1'b0;
      wait_cyc(HALF);
      ps2c = 1'b1;
    end
    wait_cyc(HALF);
    ps2d = 1'b1;
  endtask

  task automatic send_check(input string tag, input logic [7:0] d, input bit bad,
                            input logic [4:0] m, input logic [7:0] s);
    int v0, e0;
    v0 = vcnt;
    e0 = ecnt;
    send_bits(mk_frame(d, bad), 11);
    wait_cyc(10);
    check({tag, " move"},  32'(move_state), 32'(m));
    check({tag, " scan"},  32'(scan_code),  32'(s));
    check({tag, " valid"}, 32'(vcnt - v0),  bad ? 32'd0 : 32'd1);
    check({tag, " err"},   32'(ecnt - e0),  bad ? 32'd1 : 32'd0);
  endtask

  initial begin
    int v0, e0;

    add(8'h29, 0, 5'b10000, 8'h29);
    add(8'hE0, 0, 5'b10000, 8'hE0);
    add(8'h75, 0, 5'b10001, 8'h75);
    add(8'hE0, 0, 5'b10001, 8'hE0);
    add(8'hF0, 0, 5'b10001, 8'hF0);
    add(8'h75, 0, 5'b10000, 8'h75);
    add(8'h6B, 1, 5'b10000, 8'h75);   // parity flipped
    add(8'hF0, 0, 5'b10000, 8'hF0);
    add(8'h29, 0, 5'b00000, 8'h29);
    add(8'hE0, 0, 5'b00000, 8'hE0);
    add(8'h6B, 0, 5'b00010, 8'h6B);
    add(8'h75, 0, 5'b00010, 8'h75);   // keypad 8, not an arrow
    add(8'hE0, 0, 5'b00010, 8'hE0);
    add(8'h74, 0, 5'b00110, 8'h74);
    add(8'hE0, 0, 5'b00110, 8'hE0);
    add(8'h72, 0, 5'b01110, 8'h72);
    add(8'hE0, 0, 5'b01110, 8'hE0);
    add(8'h74, 0, 5'b01110, 8'h74);   // typematic repeat
    add(8'hE0, 0, 5'b01110, 8'hE0);
    add(8'hF0, 0, 5'b01110, 8'hF0);
    add(8'h72, 0, 5'b00110, 8'h72);
    add(8'hF0, 0, 5'b00110, 8'hF0);
    add(8'h29, 0, 5'b00110, 8'h29);   // break of unpressed key
    add(8'h29, 0, 5'b10110, 8'h29);
    add(8'hAA, 0, 5'b10110, 8'hAA);
    add(8'hE1, 0, 5'b10110, 8'hE1);
    add(8'hFA, 0, 5'b10110, 8'hFA);
    add(8'h1D, 0, 5'b10110 | W, 8'h1D);
    add(8'hE0, 0, 5'b10110 | W, 8'hE0);
    add(8'h74, 1, 5'b10110 | W, 8'hE0); // error clears ext
    add(8'h72, 0, 5'b10110 | W, 8'h72);
    add(8'hF0, 0, 5'b10110 | W, 8'hF0);
    add(8'h00, 1, 5'b10110 | W, 8'hF0); // error clears brk
    add(8'h29, 0, 5'b10110 | W, 8'h29);
    add(8'hE0, 0, 5'b10110 | W, 8'hE0);
    add(8'hF0, 0, 5'b10110 | W, 8'hF0);
    add(8'h74, 0, 5'b10010 | W, 8'h74);
`ifdef WASD_ALIAS_EN
    add(8'hE0, 0, 5'b10011, 8'hE0);
    add(8'h75, 0, 5'b10011, 8'h75);
    add(8'hF0, 0, 5'b10011, 8'hF0);
    add(8'h1D, 0, 5'b10011, 8'h1D);   // arrow still holds up
    add(8'hE0, 0, 5'b10011, 8'hE0);
    add(8'hF0, 0, 5'b10011, 8'hF0);
    add(8'h75, 0, 5'b10010, 8'h75);
`endif

    wait_cyc(5);
    check("reset move", 32'(move_state), 32'd0);
    check("reset scan", 32'(scan_code),  32'd0);
    check("reset valid", 32'(code_valid), 32'd0);
    check("reset err",  32'(frame_err),  32'd0);
    rst = 1'b1;
    wait_cyc(20);

    for (int i = 0; i < nvec; i++)
      send_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].bad,
                 vecs[i].exp_move, vecs[i].exp_scan);

    // Partial frame after E0 is abandoned by timeout, which also clears ext.
    send_check("to_e0", 8'hE0, 0, 5'b10010, 8'hE0);
    v0 = vcnt;
    e0 = ecnt;
    send_bits(mk_frame(8'h74, 0), 5);
    wait_cyc(TO + 10);
    check("to partial valid", 32'(vcnt - v0), 32'd0);
    check("to partial err",   32'(ecnt - e0), 32'd0);
    send_check("to_74",   8'h74, 0, 5'b10010, 8'h74);
    send_check("to_e0b",  8'hE0, 0, 5'b10010, 8'hE0);
    send_check("to_74b",  8'h74, 0, 5'b10110, 8'h74);

    // Glitches on ps2c shorter than the filter window must not strobe.
    v0 = vcnt;
    e0 = ecnt;
    for (int g = 0; g < 5; g++) begin
      ps2c = 1'b0;
      wait_cyc(1);
      ps2c = 1'b1;
      wait_cyc(30);
    end
    ps2c = 1'b0;
    wait_cyc(FL - 1);
    ps2c = 1'b1;
    wait_cyc(TO + 10);
    check("glitch valid", 32'(vcnt - v0), 32'd0);
    check("glitch err",   32'(ecnt - e0), 32'd0);
    send_check("glitch_fa", 8'hFA, 0, 5'b10110, 8'hFA);

    // Reset mid-frame after E0 clears everything, including ext.
    send_check("rs_e0", 8'hE0, 0, 5'b10110, 8'hE0);
    send_bits(mk_frame(8'h74, 0), 3);
    rst = 1'b0;
    wait_cyc(3);
    check("rs move", 32'(move_state), 32'd0);
    check("rs scan", 32'(scan_code),  32'd0);
    rst = 1'b1;
    wait_cyc(10);
    send_check("rs_74", 8'h74, 0, 5'b00000, 8'h74);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
